// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM decoding opcode/funct from the IR.
// Ports: ck/rt (clock, async active-low reset), opcode/funct in; datapath strobes out.
module mips_multicycle_ctrl (
  input  logic       ck,
  input  logic       rt,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       IorD,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       MemWrite,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUcontrole,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] alu_rtype;

  always_ff @(posedge ck or negedge rt) begin
    if (!rt) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW,
          OP_SW:    state_d = S_MEMADR;
          OP_RTYPE: state_d = S_EXEC;
          OP_BEQ:   state_d = S_BRANCH;
          OP_ADDI:  state_d = S_ADDIEX;
          OP_J:     state_d = S_JUMP;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alu_rtype = ALU_ADD;
    case (funct)
      6'b100000: alu_rtype = ALU_ADD;
      6'b100010: alu_rtype = ALU_SUB;
      6'b100100: alu_rtype = ALU_AND;
      6'b100101: alu_rtype = ALU_OR;
      6'b101010: alu_rtype = ALU_SLT;
      default:   alu_rtype = ALU_ADD;
    endcase
  end

  always_comb begin
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    PCWrite     = 1'b0;
    Branch      = 1'b0;
    MemWrite    = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    ALUcontrole = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      // branch target precomputed into ALUout
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD:  IorD = 1'b1;
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA     = 1'b1;
        ALUcontrole = alu_rtype;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUcontrole = ALU_SUB;
        Branch      = 1'b1;
        PCSrc       = 2'b01;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: scoreboard of expected states/controls.
// Expected values come from a bench-side table of the state encoding.
module tb_mips_multicycle_ctrl;

  logic       ck, rt;
  logic [5:0] opcode, funct;
  logic       IorD, IRWrite, RegDst, MemtoReg, ALUSrcA;
  logic       RegWrite, PCWrite, Branch, MemWrite;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUcontrole;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  string cur_tag;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctl;
  } exp_t;

  exp_t sb[$];

  mips_multicycle_ctrl dut (
    .ck(ck), .rt(rt), .opcode(opcode), .funct(funct),
    .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .PCWrite(PCWrite), .Branch(Branch), .MemWrite(MemWrite),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUcontrole(ALUcontrole),
    .state(state)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  wire [15:0] ctl_act = {IorD, IRWrite, RegDst, MemtoReg, ALUSrcA,
                         RegWrite, PCWrite, Branch, MemWrite,
                         ALUSrcB, PCSrc, ALUcontrole};

  function automatic logic [2:0] exp_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [15:0] exp_ctl(input int s, input logic [5:0] fn);
    logic iord, irw, rd, m2r, asa, rw, pcw, br, mw;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    {iord, irw, rd, m2r, asa, rw, pcw, br, mw} = '0;
    asb = 2'b00; pcs = 2'b00; alu = 3'b010;
    case (s)
      0:  begin irw = 1; pcw = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  iord = 1;
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; alu = exp_alu(fn); end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; alu = 3'b110; br = 1; pcs = 2'b01; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {iord, irw, rd, m2r, asa, rw, pcw, br, mw, asb, pcs, alu};
  endfunction

  task automatic check(input string tag, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_bad++;
      $error("FAIL %s %s: got %h want %h", cur_tag, tag, act, exp);
    end
  endtask

  task automatic push(input int s);
    exp_t e;
    e.st  = 4'(s);
    e.ctl = exp_ctl(s, funct);
    sb.push_back(e);
  endtask

  // one popped entry per cycle, sampled on the falling edge
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      @(negedge ck);
      e = sb.pop_front();
      check("state", {12'd0, state}, {12'd0, e.st});
      check("ctl", ctl_act, e.ctl);
    end
  endtask

  task automatic run(input string tag, input logic [5:0] op,
                     input logic [5:0] fn, input int seq[$]);
    cur_tag = tag;
    opcode  = op;
    funct   = fn;
    foreach (seq[i]) push(seq[i]);
    drain();
  endtask

  initial begin
    rt = 1'b0;
    opcode = 6'b0;
    funct = 6'b0;
    cur_tag = "reset";
    repeat (2) @(negedge ck);
    check("state", {12'd0, state}, 16'd0);
    check("ctl", ctl_act, exp_ctl(0, 6'b0));
    rt = 1'b1;

    run("lw",   6'b100011, 6'b000000, '{1, 2, 3, 4, 0});
    run("sw",   6'b101011, 6'b000000, '{1, 2, 5, 0});
    run("sub",  6'b000000, 6'b100010, '{1, 6, 7, 0});
    run("add",  6'b000000, 6'b100000, '{1, 6, 7, 0});
    run("and",  6'b000000, 6'b100100, '{1, 6, 7, 0});
    run("or",   6'b000000, 6'b100101, '{1, 6, 7, 0});
    run("slt",  6'b000000, 6'b101010, '{1, 6, 7, 0});
    run("fnx",  6'b000000, 6'b111111, '{1, 6, 7, 0});
    run("beq",  6'b000100, 6'b000000, '{1, 8, 0});
    run("addi", 6'b001000, 6'b000000, '{1, 9, 10, 0});
    run("j",    6'b000010, 6'b000000, '{1, 11, 0});
    run("ill",  6'b111111, 6'b000000, '{1, 0});

    // reset pulse in MEMWB must kill RegWrite without waiting for a clock
    run("lw2",  6'b100011, 6'b000000, '{1, 2, 3, 4});
    cur_tag = "rst_mid";
    #1 rt = 1'b0;
    #1;
    check("state", {12'd0, state}, 16'd0);
    check("regwr", {15'd0, RegWrite}, 16'd0);
    check("ctl", ctl_act, exp_ctl(0, 6'b0));
    @(negedge ck);
    check("hold", {12'd0, state}, 16'd0);
    rt = 1'b1;
    run("post", 6'b100011, 6'b000000, '{1, 2, 3, 4, 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
